// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus of the restoring divider.
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_SIGNED_EN: two's-complement operands via sign/magnitude wrap.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seq_restoring_divider_if.slave      bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   sub_a, sub_b, diff;
    logic [WIDTH+1:0] borrow;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] quo_fin, rem_fin;
    logic [WIDTH-1:0] load_dvd, load_dvs;

`ifdef DIV_SIGNED_EN
    logic sign_q_q, sign_q_d;
    logic sign_r_q, sign_r_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (WIDTH'(0) - x) : x;
    endfunction

    assign load_dvd = mag(bus.dividend);
    assign load_dvs = mag(bus.divisor);
    assign quo_fin  = sign_q_q ? (WIDTH'(0) - quo_nx) : quo_nx;
    assign rem_fin  = sign_r_q ? (WIDTH'(0) - rem_nx) : rem_nx;
`else
    assign load_dvd = bus.dividend;
    assign load_dvs = bus.divisor;
    assign quo_fin  = quo_nx;
    assign rem_fin  = rem_nx;
`endif

    // One iteration: shift {rem,quo}, then WIDTH+1-bit ripple-borrow trial subtract.
    always_comb begin
        rem_sh    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        sub_a     = {1'b0, rem_sh};
        sub_b     = {1'b0, dvs_q};
        diff      = '0;
        borrow    = '0;
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            diff[i]       = sub_a[i] ^ sub_b[i] ^ borrow[i];
            borrow[i + 1] = (~sub_a[i] & sub_b[i]) | (~(sub_a[i] ^ sub_b[i]) & borrow[i]);
        end
        rem_nx = diff[WIDTH] ? rem_sh : diff[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                        rem_d   = '0;
                        quo_d   = load_dvd;
                        dvs_d   = load_dvs;
                        cnt_d   = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                        sign_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r_d = bus.dividend[WIDTH-1];
`endif
                    end
                end
            end
            ST_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = quo_fin;
                    remainder_d = rem_fin;
                    dbz_d       = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed plus random checks of seq_restoring_divider against an arithmetic reference model.
module tb_seq_restoring_divider;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [W-1:0] last_q, last_r;
    logic         last_z;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int ia, ib;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            ia = $signed(a);
            ib = $signed(b);
`else
            ia = int'(a);
            ib = int'(b);
`endif
            q = W'(ia / ib);
            r = W'(ia % ib);
            z = 1'b0;
        end
    endfunction

    // Issue one operation; poke >= 0 re-pulses start (with junk operands) mid-iteration.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke);
        logic [W-1:0] eq, er;
        logic         ez;
        model(a, b, eq, er, ez);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        if (b != '0) begin
            for (int cyc = 0; cyc < int'(W); cyc++) begin
                chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
                chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
                chk({tag, "_q_hold"}, 32'(bus.quotient), 32'(last_q));
                chk({tag, "_r_hold"}, 32'(bus.remainder), 32'(last_r));
                if (cyc == poke) begin
                    bus.start    = 1'b1;
                    bus.dividend = 8'd50;
                    bus.divisor  = 8'd5;
                end else begin
                    bus.start = 1'b0;
                end
                if (cyc < int'(W) - 1) @(negedge clk);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
        last_q = eq;
        last_r = er;
        last_z = ez;
        // start during DONE must be ignored
        bus.start    = 1'b1;
        bus.dividend = ~a;
        bus.divisor  = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_ign_in_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_res_held"}, 32'(bus.quotient), 32'(eq));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        checks = 0;
        errors = 0;
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);
        chk("rst_z", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;

`ifdef DIV_SIGNED_EN
        run_op("s_m100_7", 8'h9C, 8'd7, -1);
        chk("s_m100_7_q_lit", 32'(bus.quotient), 32'hF2);
        chk("s_m100_7_r_lit", 32'(bus.remainder), 32'hFE);
        run_op("s_m128_m1", 8'h80, 8'hFF, -1);
        chk("s_m128_m1_q_lit", 32'(bus.quotient), 32'h80);
        chk("s_m128_m1_r_lit", 32'(bus.remainder), 32'h00);
        run_op("s_7_m2", 8'd7, 8'hFE, -1);
        run_op("s_div0", 8'hF0, 8'd0, -1);
`else
        run_op("u_100_7", 8'd100, 8'd7, -1);
        chk("u_100_7_q_lit", 32'(bus.quotient), 32'd14);
        chk("u_100_7_r_lit", 32'(bus.remainder), 32'd2);
        run_op("u_255_1", 8'd255, 8'd1, -1);
        run_op("u_5_9", 8'd5, 8'd9, -1);
        chk("u_5_9_r_lit", 32'(bus.remainder), 32'd5);
        run_op("u_37_0", 8'd37, 8'd0, -1);
        chk("u_37_0_q_lit", 32'(bus.quotient), 32'hFF);
        run_op("u_10_3", 8'd10, 8'd3, -1);
        chk("u_10_3_z_clear", 32'(bus.div_by_zero), 32'd0);
        run_op("u_200_13_poke", 8'd200, 8'd13, 3);
        chk("u_200_13_q_lit", 32'(bus.quotient), 32'd15);
        chk("u_200_13_r_lit", 32'(bus.remainder), 32'd5);
`endif

        // Reset mid-iteration: outputs clear at once and the aborted op never completes.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd13;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_q", 32'(bus.quotient), 32'd0);
        chk("mid_rst_r", 32'(bus.remainder), 32'd0);
        chk("mid_rst_z", 32'(bus.div_by_zero), 32'd0);
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'(bus.done), 32'd0);
        end
        run_op("post_rst_9_2", 8'd9, 8'd2, -1);

        // Randomized operands, occasional zero divisor and stray start pulses.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op("rand", ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
